// File: rtl/score_display.sv
// score_display: converts the 7-bit game score to two BCD digits with a
// sequential shift-add-3 converter, and scans a 4-digit active-low
// common-anode 7-segment display (lives, blank, tens, ones).
// Optional build macro: SCORE_LEADING_ZERO_BLANK_EN blanks the tens digit
// on the display whenever it is zero. The BCD outputs are identical in
// both builds.
module score_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] score,
    input  logic [1:0] lives,
    output logic [3:0] tens_bcd,
    output logic [3:0] ones_bcd,
    output logic       busy,
    output logic       conv_done,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] REFRESH_TERM = CW'(REFRESH_DIV - 1);
    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_r;
    logic [6:0]  last_score_r;
    logic [6:0]  latched_r;
    logic [6:0]  shift_r;
    logic [7:0]  bcd_r;
    logic [2:0]  iter_r;
    logic [3:0]  tens_r;
    logic [3:0]  ones_r;
    logic        busy_r;
    logic        conv_done_r;
    logic [CW-1:0] refresh_cnt_r;
    logic [1:0]  digit_sel_r;
    logic [3:0]  an_r;
    logic [6:0]  seg_r;

    logic [6:0]  sat_score_s;
    logic [7:0]  bcd_adj_s;
    logic [3:0]  digit_code_s;

    // Double-dabble correction: a nibble of 5 or more becomes >=8 after +3,
    // so the following shift carries it into the next decade.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    // Active-low segment pattern {g,f,e,d,c,b,a}; any non-decimal code is blank.
    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    // Saturate the score at 99 and precompute the corrected accumulator.
    always_comb begin
        sat_score_s = score;
        if (score > 7'd99) begin
            sat_score_s = 7'd99;
        end else begin
            sat_score_s = score;
        end
        bcd_adj_s = {add3(bcd_r[7:4]), add3(bcd_r[3:0])};
    end

    // Select the BCD code shown on the digit currently being scanned.
    always_comb begin
        digit_code_s = BLANK_CODE;
        case (digit_sel_r)
            2'd0: digit_code_s = ones_r;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
            2'd1: begin
                if (tens_r == 4'd0) begin
                    digit_code_s = BLANK_CODE;
                end else begin
                    digit_code_s = tens_r;
                end
            end
`else
            2'd1: digit_code_s = tens_r;
`endif
            2'd2: digit_code_s = BLANK_CODE;
            2'd3: digit_code_s = {2'b00, lives};
            default: digit_code_s = BLANK_CODE;
        endcase
    end

    // Conversion FSM: watch for a new score, shift 7 times, publish the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            last_score_r <= 7'd0;
            latched_r    <= 7'd0;
            shift_r      <= 7'd0;
            bcd_r        <= 8'd0;
            iter_r       <= 3'd0;
            tens_r       <= 4'd0;
            ones_r       <= 4'd0;
            busy_r       <= 1'b0;
            conv_done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    conv_done_r <= 1'b0;
                    if (sat_score_s != last_score_r) begin
                        latched_r <= sat_score_s;
                        shift_r   <= sat_score_s;
                        bcd_r     <= 8'd0;
                        iter_r    <= 3'd7;
                        busy_r    <= 1'b1;
                        state_r   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bcd_r   <= {bcd_adj_s[6:0], shift_r[6]};
                    shift_r <= {shift_r[5:0], 1'b0};
                    iter_r  <= iter_r - 3'd1;
                    if (iter_r == 3'd1) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    tens_r       <= bcd_r[7:4];
                    ones_r       <= bcd_r[3:0];
                    last_score_r <= latched_r;
                    conv_done_r  <= 1'b1;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    busy_r      <= 1'b0;
                    conv_done_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // Scan timer: hold each digit REFRESH_DIV cycles, then advance digit_sel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt_r <= '0;
            digit_sel_r   <= 2'd0;
        end else if (refresh_cnt_r == REFRESH_TERM) begin
            refresh_cnt_r <= '0;
            digit_sel_r   <= digit_sel_r + 2'd1;
        end else begin
            refresh_cnt_r <= refresh_cnt_r + CW'(1);
        end
    end

    // Register anode and segment drive one cycle behind digit_sel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_r  <= 4'b1111;
            seg_r <= 7'b1111111;
        end else begin
            an_r  <= ~(4'b0001 << digit_sel_r);
            seg_r <= glyph(digit_code_s);
        end
    end

    assign tens_bcd  = tens_r;
    assign ones_bcd  = ones_r;
    assign busy      = busy_r;
    assign conv_done = conv_done_r;
    assign an        = an_r;
    assign seg       = seg_r;

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display (REFRESH_DIV=4): expected BCD results
// are queued when a score is applied and checked on every conv_done pulse.
module tb_score_display;

    logic       clk;
    logic       rst;
    logic [6:0] score;
    logic [1:0] lives;
    logic [3:0] tens_bcd;
    logic [3:0] ones_bcd;
    logic       busy;
    logic       conv_done;
    logic [3:0] an;
    logic [6:0] seg;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pulse = 0;
    logic [7:0] exp_q[$];

    score_display #(.REFRESH_DIV(4)) dut (
        .clk(clk), .rst(rst), .score(score), .lives(lives),
        .tens_bcd(tens_bcd), .ones_bcd(ones_bcd), .busy(busy),
        .conv_done(conv_done), .an(an), .seg(seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Expected segments for lives=2, score=5 per active anode.
    function automatic logic [6:0] exp_seg(input logic [3:0] a);
        case (a)
            4'b1110: return 7'b0010010;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
            4'b1101: return 7'b1111111;
`else
            4'b1101: return 7'b1000000;
`endif
            4'b1011: return 7'b1111111;
            4'b0111: return 7'b0100100;
            default: return 7'b0000000;
        endcase
    endfunction

    // Monitor: every conv_done pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (!rst && conv_done) begin
            n_pulse++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL conv_unexpected: got %0h%0h required no pulse", tens_bcd, ones_bcd);
            end else begin
                check("conv_bcd", {24'd0, tens_bcd, ones_bcd}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic wait_quiet(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !conv_done) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] prev_an;
        logic [3:0] cur_an;
        int hold;
        int p0;

        rst = 1'b1;
        score = 7'd0;
        lives = 2'd0;
        #2;
        check("rst_an", an, 4'b1111);
        check("rst_seg", seg, 7'b1111111);
        check("rst_bcd", {tens_bcd, ones_bcd}, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", conv_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_an", an, 4'b1110);
        check("post_rst_seg", seg, 7'b1000000);
        check("post_rst_busy", busy, 1'b0);

        // 0 -> 47: busy for 8 cycles, single conv_done pulse.
        @(negedge clk);
        score = 7'd47;
        exp_q.push_back(8'h47);
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("busy_47", busy, 1'b1);
        end
        @(negedge clk);
        check("busy_47_end", busy, 1'b0);
        check("done_47", conv_done, 1'b1);
        @(negedge clk);
        check("done_47_drop", conv_done, 1'b0);

        // Saturation: 127 shows 99; then 99 needs no conversion.
        score = 7'd127;
        exp_q.push_back(8'h99);
        wait_quiet("quiet_127");
        score = 7'd99;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("busy_99_none", busy, 1'b0);
        end

        // 12 then 13 during the 3rd SHIFT cycle: two pulses, 12 then 13.
        p0 = n_pulse;
        score = 7'd12;
        exp_q.push_back(8'h12);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        score = 7'd13;
        exp_q.push_back(8'h13);
        wait_quiet("quiet_13");
        check("pulses_12_13", n_pulse - p0, 32'd2);

        // Display scan with lives=2, score=5.
        lives = 2'd2;
        score = 7'd5;
        exp_q.push_back(8'h05);
        wait_quiet("quiet_5");
        prev_an = an;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (an != prev_an) break;
        end
        for (int p = 0; p < 8; p++) begin
            cur_an = an;
            check("scan_seg", seg, exp_seg(cur_an));
            hold = 1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (an != cur_an) break;
                hold++;
            end
            check("scan_hold", hold, 32'd4);
            check("scan_next_an", an, {cur_an[2:0], cur_an[3]});
        end

        // Async reset during SHIFT for 88, then reconvert after release.
        @(negedge clk);
        score = 7'd88;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_bcd", {tens_bcd, ones_bcd}, 8'h00);
        check("midrst_an", an, 4'b1111);
        check("midrst_seg", seg, 7'b1111111);
        @(negedge clk);
        @(negedge clk);
        exp_q.push_back(8'h88);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rel_an", an, 4'b1110);
        check("rel_seg", seg, 7'b1000000);
        check("rel_busy", busy, 1'b1);
        wait_quiet("quiet_88");
        check("final_bcd", {tens_bcd, ones_bcd}, 8'h88);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
